// File: rtl/tanque_sim.sv
// tanque_sim: closed-loop tank plant model for the irrigation controller.
// It integrates inlet/outlet flows on a prescaled tick, saturates at empty
// and full, and drives thermometer-coded level sensors plus sticky flags.
module tanque_sim #(
    parameter int TICK_DIV   = 1000,
    parameter int CAP        = 200,
    parameter int INIT_LEVEL = 0,
    parameter int IN_RATE    = 10,
    parameter int VS_RATE    = 6,
    parameter int BS_RATE    = 2,
    parameter int L_TH       = 20,
    parameter int M_TH       = 100,
    parameter int H_TH       = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ve,
    input  logic       vs,
    input  logic       bs,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       l,
    output logic       m,
    output logic       h,
    output logic [7:0] nivel,
    output logic       tick,
    output logic       ovf,
    output logic       dry
);

    localparam int PC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);
    localparam logic [7:0] CAP8  = 8'(CAP);
    localparam logic [7:0] INIT8 = 8'(INIT_LEVEL);

    // Thresholds indexed low/middle/high so sensor bits come out as l/m/h.
    localparam logic [7:0] TH [3] = '{8'(L_TH), 8'(M_TH), 8'(H_TH)};

    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_nivel;
    logic [2:0]        r_sens;
    logic              r_tick;
    logic              r_ovf;
    logic              r_dry;

    logic              w_tick_now;
    logic [PC_W-1:0]   w_pc_next;
    logic signed [9:0] w_in;
    logic signed [9:0] w_out_vs;
    logic signed [9:0] w_out_bs;
    logic signed [9:0] w_sum;
    logic              w_over;
    logic              w_under;
    logic [7:0]        w_upd_level;
    logic [7:0]        w_load_level;
    logic [7:0]        w_next_level;
    logic [2:0]        w_next_sens;
    logic [2:0]        w_init_sens;

    // The update edge is the one that ends the cycle in which pc is at its last count.
    assign w_tick_now = (r_pc == PC_LAST);
    // A load restarts the prescaler so the next tick is a full period away.
    assign w_pc_next  = (load || w_tick_now) ? '0 : r_pc + 1'b1;

    // Net flow in 10-bit signed so neither overflow above 255 nor underflow wraps.
    assign w_in     = ve ? $signed(10'(IN_RATE)) : 10'sd0;
    assign w_out_vs = vs ? $signed(10'(VS_RATE)) : 10'sd0;
    assign w_out_bs = bs ? $signed(10'(BS_RATE)) : 10'sd0;
    assign w_sum    = $signed({2'b00, r_nivel}) + w_in - w_out_vs - w_out_bs;

    assign w_over  = (w_sum > $signed(10'(CAP)));
    assign w_under = (w_sum < 10'sd0);

    assign w_upd_level  = w_over ? CAP8 : (w_under ? 8'd0 : w_sum[7:0]);
    assign w_load_level = (load_val > CAP8) ? CAP8 : load_val;
    assign w_next_level = load ? w_load_level : w_upd_level;

    // Sensor bits are plain threshold compares; ordered thresholds make the code a thermometer.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sens
            assign w_next_sens[gi] = (w_next_level >= TH[gi]);
            assign w_init_sens[gi] = (INIT8 >= TH[gi]);
        end
    endgenerate

    // Prescaler, level integration, sensors and sticky flags, all on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_nivel <= INIT8;
            r_sens  <= w_init_sens;
            r_tick  <= 1'b0;
            r_ovf   <= 1'b0;
            r_dry   <= 1'b0;
        end else begin
            r_pc   <= w_pc_next;
            r_tick <= (w_pc_next == PC_LAST);
            if (load) begin
                r_nivel <= w_next_level;
                r_sens  <= w_next_sens;
                r_ovf   <= 1'b0;
                r_dry   <= 1'b0;
            end else if (w_tick_now) begin
                r_nivel <= w_next_level;
                r_sens  <= w_next_sens;
                if (ve && w_over) begin
                    r_ovf <= 1'b1;
                end
                if ((vs || bs) && w_under) begin
                    r_dry <= 1'b1;
                end
            end
        end
    end

    assign nivel = r_nivel;
    assign l     = r_sens[0];
    assign m     = r_sens[1];
    assign h     = r_sens[2];
    assign tick  = r_tick;
    assign ovf   = r_ovf;
    assign dry   = r_dry;

endmodule

// File: tb/tb_tanque_sim.sv
// tb_tanque_sim: directed scoreboard bench for tanque_sim with TICK_DIV=4.
// Stimulus pushes the expected state for every reset/tick/load edge; the
// monitor pops on each such edge and checks hold behaviour on all others.
module tb_tanque_sim;

    logic       clk = 1'b0;
    logic       rst;
    logic       ve;
    logic       vs;
    logic       bs;
    logic       load;
    logic [7:0] load_val;
    logic       l;
    logic       m;
    logic       h;
    logic [7:0] nivel;
    logic       tick;
    logic       ovf;
    logic       dry;

    tanque_sim #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ve       (ve),
        .vs       (vs),
        .bs       (bs),
        .load     (load),
        .load_val (load_val),
        .l        (l),
        .m        (m),
        .h        (h),
        .nivel    (nivel),
        .tick     (tick),
        .ovf      (ovf),
        .dry      (dry)
    );

    always #5 clk = ~clk;

    // kind: 0 = reset edge, 1 = tick update edge, 2 = load edge
    typedef struct {
        int       edge_n;
        int       kind;
        bit       ptick;
        bit [7:0] lvl;
        bit       el;
        bit       em;
        bit       eh;
        bit       eovf;
        bit       edry;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   e     = 1;   // number of the next rising edge the current inputs apply to

    task automatic chk(input string name, input int edge_n, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, edge_n, act, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        e++;
    endtask

    task automatic expect_ev(input int kind, input bit ptick, input int lvl, input bit eovf, input bit edry);
        exp_t x;
        x.edge_n = e;
        x.kind   = kind;
        x.ptick  = ptick;
        x.lvl    = 8'(lvl);
        x.el     = (lvl >= 20);
        x.em     = (lvl >= 100);
        x.eh     = (lvl >= 180);
        x.eovf   = eovf;
        x.edry   = edry;
        q.push_back(x);
    endtask

    // Three quiet edges, then the update edge (assumes pc was just cleared).
    task automatic do_tick(input int lvl, input bit eovf, input bit edry);
        repeat (3) step();
        expect_ev(1, 1'b1, lvl, eovf, edry);
        step();
    endtask

    task automatic do_load(input int val, input int lvl);
        load     = 1'b1;
        load_val = 8'(val);
        expect_ev(2, 1'b0, lvl, 1'b0, 1'b0);
        step();
        load = 1'b0;
    endtask

    // Monitor: classify each edge, pop and compare on events, check hold otherwise.
    initial begin
        int   mcount = 0;
        bit   pre_rst, pre_load, pre_tick;
        int   obs_kind;
        bit   have_last = 1'b0;
        exp_t x;
        exp_t last;
        forever begin
            @(posedge clk);
            mcount++;
            pre_rst  = (rst === 1'b1);
            pre_load = (load === 1'b1);
            pre_tick = (tick === 1'b1);
            #1;
            obs_kind = pre_rst ? 0 : (pre_load ? 2 : (pre_tick ? 1 : -1));
            if (obs_kind >= 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", mcount, 32'(obs_kind), 32'hFFFF_FFFF);
                end else begin
                    x = q.pop_front();
                    chk("event_edge", mcount, 32'(mcount), 32'(x.edge_n));
                    chk("event_kind", mcount, 32'(obs_kind), 32'(x.kind));
                    if (x.kind != 0) chk("tick_pulse", mcount, 32'(pre_tick), 32'(x.ptick));
                    chk("nivel", mcount, 32'(nivel), 32'(x.lvl));
                    chk("sens_lmh", mcount, 32'({l, m, h}), 32'({x.el, x.em, x.eh}));
                    chk("ovf", mcount, 32'(ovf), 32'(x.eovf));
                    chk("dry", mcount, 32'(dry), 32'(x.edry));
                    chk("tick_after", mcount, 32'(tick), 32'd0);
                    last      = x;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("hold_nivel", mcount, 32'(nivel), 32'(last.lvl));
                chk("hold_sens", mcount, 32'({l, m, h}), 32'({last.el, last.em, last.eh}));
                chk("hold_flags", mcount, 32'({ovf, dry}), 32'({last.eovf, last.edry}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        // 1. reset for two edges with random actuator inputs
        rst      = 1'b1;
        load     = 1'b0;
        load_val = 8'($urandom);
        ve       = 1'($urandom);
        vs       = 1'($urandom);
        bs       = 1'($urandom);
        expect_ev(0, 1'b0, 0, 1'b0, 1'b0);
        step();
        expect_ev(0, 1'b0, 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;

        // 2. fill with the inlet only; clamp at 200, overflow on tick 21
        ve = 1'b1;
        vs = 1'b0;
        bs = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            do_tick((10 * k > 200) ? 200 : 10 * k, (k >= 21), 1'b0);
        end

        // 3. all actuators from 100: +2 per tick, then drop the inlet mid-interval
        vs = 1'b1;
        bs = 1'b1;
        do_load(100, 100);
        do_tick(102, 1'b0, 1'b0);
        do_tick(104, 1'b0, 1'b0);
        do_tick(106, 1'b0, 1'b0);
        do_tick(108, 1'b0, 1'b0);
        do_tick(110, 1'b0, 1'b0);
        repeat (2) step();
        ve = 1'b0;
        step();
        expect_ev(1, 1'b1, 102, 1'b0, 1'b0);
        step();

        // 4. dry run from 4 with the sprinkler, then a load clears the flag
        bs = 1'b0;
        do_load(4, 4);
        do_tick(0, 1'b0, 1'b1);
        do_load(50, 50);

        // 5. load colliding with a tick: load wins, value clamped, tick still pulses
        vs = 1'b0;
        ve = 1'b1;
        repeat (3) step();
        load     = 1'b1;
        load_val = 8'd250;
        expect_ev(2, 1'b1, 200, 1'b0, 1'b0);
        step();
        load = 1'b0;
        do_tick(200, 1'b1, 1'b0);

        // 6. reset mid-fill at level 60, pc=2; next tick a full period after release
        do_load(60, 60);
        repeat (2) step();
        rst = 1'b1;
        expect_ev(0, 1'b0, 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        do_tick(10, 1'b0, 1'b0);
        ve = 1'b0;
        repeat (3) step();

        chk("queue_drained", e, 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tanque_sim.md
# tanque_sim

Closed-loop plant model for the irrigation controller: it consumes the actuator commands the controller drives (inlet valve `ve`, sprinkler valve `vs`, drip pump `bs`) and produces the tank level sensor bits (`h`, `m`, `l`) the controller reads. It integrates inflow and outflow on a prescaled tick, saturates at empty and full, and raises sticky overflow/dry-run flags. It sits between the controller outputs and sensor inputs on the FPGA board, so the full system can be exercised without a physical tank.

## Interface
- `TICK_DIV`, 1000 — clock cycles per level-update tick (≥2)
- `CAP`, 200 — full-tank level (≤255)
- `INIT_LEVEL`, 0 — level after reset (≤CAP)
- `IN_RATE`, 10 — units added per tick while `ve`=1
- `VS_RATE`, 6 — units removed per tick while `vs`=1
- `BS_RATE`, 2 — units removed per tick while `bs`=1
- `L_TH`, 20 / `M_TH`, 100 / `H_TH`, 180 — sensor thresholds (L_TH<M_TH<H_TH≤CAP)
- `clk` in 1 — system clock
- `rst` in 1 — synchronous reset, active-high
- `ve` in 1 — inlet valve open
- `vs` in 1 — sprinkler valve open
- `bs` in 1 — drip pump on
- `load` in 1 — one-cycle strobe: force level to `load_val`
- `load_val` in 8 — level to load, clamped to CAP
- `l` out 1 — water at or above low sensor
- `m` out 1 — water at or above middle sensor
- `h` out 1 — water at or above high sensor
- `nivel` out 8 — current level
- `tick` out 1 — one-cycle pulse on each update edge
- `ovf` out 1 — sticky: inflow attempted while full
- `dry` out 1 — sticky: outflow demanded while empty

## Operation
- Prescaler `pc`: counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle when `pc`=TICK_DIV-1; the level updates on that clock edge.
- On a tick, `ve`/`vs`/`bs` are sampled on that same edge, and next = nivel + (ve?IN_RATE:0) − (vs?VS_RATE:0) − (bs?BS_RATE:0).
  - Compute in signed 10-bit arithmetic with no intermediate wrap.
  - If next > CAP, then nivel=CAP. If next < 0, then nivel=0.
- `ovf` sets on a tick when `ve`=1 and pre-saturation next > CAP.
- `dry` sets on a tick when (`vs`|`bs`)=1 and pre-saturation next < 0.
- Both flags stay set until `rst` or `load`.
- Sensors are a thermometer code registered from the new level on the same edge as `nivel`:
  - `l`=(nivel≥L_TH), `m`=(nivel≥M_TH), `h`=(nivel≥H_TH).
  - Invalid combinations (e.g. `h`=1,`m`=0) never occur.
- `load`=1:
  - Sets nivel=min(load_val,CAP) and recomputes the sensors on the same edge.
  - Clears `ovf` and `dry`, and resets `pc` to 0.
  - Takes priority over a coincident tick; the tick's update is discarded, and `tick` still pulses.
- Between ticks, `nivel`, sensors and flags hold their values regardless of input changes.

## Timing
- Reset values:
  - `pc`=0, `nivel`=INIT_LEVEL, sensors as the thermometer code of INIT_LEVEL.
  - `tick`=0, `ovf`=0, `dry`=0.
- `rst` has priority over `load`.
- Reset mid-operation discards any in-progress tick count.
- First update occurs at the TICK_DIV-th rising edge after the `rst` deassertion edge. Subsequent updates come every TICK_DIV cycles.
- Latency from input change to sensor change: at most TICK_DIV cycles. Inputs are sampled only at the tick edge.
- `load` latency is 1 cycle: outputs reflect the loaded value immediately after the edge.
- Simultaneous `ve`,`vs`,`bs` give a net rate of IN_RATE−VS_RATE−BS_RATE (+2 at defaults).
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All scenarios use TICK_DIV=4 with the other parameters at their defaults.

1. Reset: hold `rst` 2 cycles with random inputs -> nivel=0, h/m/l=0/0/0, ovf=dry=0, tick=0; first `tick` at the 4th edge after release.
2. Fill, `ve`=1 only, from 0:
   - After 2 ticks, nivel=20 and `l`=1.
   - After 10 ticks, nivel=100 and `m`=1.
   - After 18 ticks, nivel=180 and `h`=1.
   - After 20 ticks, nivel=200 with ovf=0.
   - Tick 21: nivel=200 and ovf=1.
3. All actuators on from nivel=100 (via `load`): nivel=102 after 1 tick and 110 after 5 ticks. Dropping `ve` between ticks changes nothing until the next tick, then nivel=102 (110−8).
4. Dry run: load 4, `vs`=1 -> next tick nivel=0, dry=1, l=0. Then load 50 -> dry=0, nivel=50, l=1, m=0.
5. Load/tick collision: assert `load`=1 with load_val=250 in the cycle where tick=1 -> nivel=200 (clamped), h=1. Next tick arrives 4 cycles later.
6. Reset mid-fill: at nivel=60, pc=2, assert `rst` -> nivel=0, sensors 0. Next tick comes 4 cycles after release, not 2.
